// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754 adder/subtractor, parametrised exponent/mantissa widths.
// RNE rounding, DAZ/FTZ, NaN/inf handling, strt/valid/busy handshake.
//
// state | meaning
// IDLE  | waiting for strt, result and flags held
// ALIGN | order operands, align smaller significand, decode specials
// ADD   | add or subtract aligned significands
// NORM  | normalise, detect zero and underflow
// ROUND | round to nearest even, write result, pulse valid
module fp_addsub #(
  parameter int EXP = 8,
  parameter int MAN = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt,
  input  logic             op,
  input  logic [EXP+MAN:0] input1,
  input  logic [EXP+MAN:0] input2,
  output logic [EXP+MAN:0] out,
  output logic             valid,
  output logic             busy,
  output logic             invalid,
  output logic             overflow,
  output logic             inexact
);

  localparam int W  = EXP + MAN + 1;
  localparam int SW = MAN + 4;
  localparam int EW = EXP + 2 + $clog2(MAN + 5);
  localparam logic [EXP-1:0] EMAX = '1;
  localparam logic signed [EW-1:0] EXP_INF = EW'((1 << EXP) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

  state_t               state;
  logic [W-1:0]         a_r, b_r;
  logic                 op_r;
  logic                 sign_r, sub_r;
  logic signed [EW-1:0] exp_r;
  logic [SW-1:0]        big_r, small_r;
  logic [SW:0]          sum_r;
  logic                 spec_r, spec_inv_r, zero_r, ftz_r;
  logic [W-1:0]         spec_out_r;

  // align stage
  logic [EXP-1:0] ea, eb, e_big, e_small;
  logic [MAN-1:0] ma, mb;
  logic           sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [W-2:0]   mag_a, mag_b;
  logic [SW-1:0]  sig_a, sig_b, sig_big, sig_small, shifted;
  logic [EXP:0]   d;
  int             sh;
  logic           al_spec, al_inv;
  logic [W-1:0]   al_out;

  always_comb begin
    ea = a_r[W-2:MAN];
    eb = b_r[W-2:MAN];
    ma = a_r[MAN-1:0];
    mb = b_r[MAN-1:0];
    sa = a_r[W-1];
    sb = b_r[W-1] ^ op_r;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EMAX) && (ma == '0);
    b_inf  = (eb == EMAX) && (mb == '0);
    a_nan  = (ea == EMAX) && (ma != '0);
    b_nan  = (eb == EMAX) && (mb != '0);
    // subnormals compare and add as zero
    mag_a = a_zero ? '0 : a_r[W-2:0];
    mag_b = b_zero ? '0 : b_r[W-2:0];
    sig_a = a_zero ? '0 : {1'b1, ma, 3'b000};
    sig_b = b_zero ? '0 : {1'b1, mb, 3'b000};
    swap      = (mag_b > mag_a);
    e_big     = swap ? eb : ea;
    e_small   = swap ? ea : eb;
    sig_big   = swap ? sig_b : sig_a;
    sig_small = swap ? sig_a : sig_b;
    d  = {1'b0, e_big} - {1'b0, e_small};
    sh = (int'(d) > MAN + 3) ? MAN + 3 : int'(d);
    shifted    = sig_small >> sh;
    shifted[0] = shifted[0] | (|(sig_small & ~({SW{1'b1}} << sh)));
    al_spec = 1'b1;
    al_inv  = 1'b0;
    al_out  = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      al_out = QNAN;
      al_inv = 1'b1;
    end else if (a_inf) begin
      al_out = {sa, EMAX, {MAN{1'b0}}};
    end else if (b_inf) begin
      al_out = {sb, EMAX, {MAN{1'b0}}};
    end else if (a_zero && b_zero) begin
      al_out = {sa & sb, {(W-1){1'b0}}};
    end else begin
      al_spec = 1'b0;
    end
  end

  // normalise stage
  int                   lz;
  logic [SW-1:0]        n_sig;
  logic signed [EW-1:0] n_exp;

  always_comb begin
    lz = SW;
    for (int i = 0; i < SW; i++)
      if (sum_r[i]) lz = SW - 1 - i;
    if (sum_r[SW]) begin
      n_sig = {sum_r[SW:2], sum_r[1] | sum_r[0]};
      n_exp = exp_r + EW'(1);
    end else begin
      n_sig = sum_r[SW-1:0] << lz;
      n_exp = exp_r - EW'(lz);
    end
  end

  // round stage
  logic                 g, r, s, inc;
  logic [MAN+1:0]       rnd;
  logic signed [EW-1:0] r_exp;
  logic [MAN-1:0]       r_man;

  always_comb begin
    g   = big_r[2];
    r   = big_r[1];
    s   = big_r[0];
    inc = g & (r | s | big_r[3]);
    rnd = {1'b0, big_r[SW-1:3]} + (MAN+2)'(inc);
    r_exp = rnd[MAN+1] ? exp_r + EW'(1) : exp_r;
    r_man = rnd[MAN+1] ? rnd[MAN:1] : rnd[MAN-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= 1'b0;
      sign_r     <= 1'b0;
      sub_r      <= 1'b0;
      exp_r      <= '0;
      big_r      <= '0;
      small_r    <= '0;
      sum_r      <= '0;
      spec_r     <= 1'b0;
      spec_inv_r <= 1'b0;
      spec_out_r <= '0;
      zero_r     <= 1'b0;
      ftz_r      <= 1'b0;
      out        <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      invalid    <= 1'b0;
      overflow   <= 1'b0;
      inexact    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (strt) begin
            a_r   <= input1;
            b_r   <= input2;
            op_r  <= op;
            busy  <= 1'b1;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          sign_r     <= swap ? sb : sa;
          sub_r      <= (sa != sb);
          exp_r      <= EW'(e_big);
          big_r      <= sig_big;
          small_r    <= shifted;
          spec_r     <= al_spec;
          spec_inv_r <= al_inv;
          spec_out_r <= al_out;
          state      <= ADD;
        end
        ADD: begin
          sum_r <= sub_r ? {1'b0, big_r} - {1'b0, small_r}
                         : {1'b0, big_r} + {1'b0, small_r};
          state <= NORM;
        end
        NORM: begin
          big_r  <= n_sig;
          exp_r  <= n_exp;
          zero_r <= (sum_r == '0);
          ftz_r  <= (sum_r != '0) && (n_exp <= 0);
          state  <= ROUND;
        end
        ROUND: begin
          invalid  <= 1'b0;
          overflow <= 1'b0;
          inexact  <= 1'b0;
          if (spec_r) begin
            out     <= spec_out_r;
            invalid <= spec_inv_r;
          end else if (zero_r) begin
            out <= '0;
          end else if (ftz_r) begin
            out     <= {sign_r, {(W-1){1'b0}}};
            inexact <= 1'b1;
          end else if (r_exp >= EXP_INF) begin
            out      <= {sign_r, EMAX, {MAN{1'b0}}};
            overflow <= 1'b1;
            inexact  <= 1'b1;
          end else begin
            out     <= {sign_r, r_exp[EXP-1:0], r_man};
            inexact <= g | r | s;
          end
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
